// File: rtl/deadtime_pkg.sv
// Shared state encoding and constants for the half-bridge dead-time generator.
package deadtime_pkg;

  typedef logic [2:0] state_t;

  localparam state_t STATE_OFF     = 3'd0;
  localparam state_t STATE_LOW_ON  = 3'd1;
  localparam state_t STATE_DEAD_LH = 3'd2;
  localparam state_t STATE_HIGH_ON = 3'd3;
  localparam state_t STATE_DEAD_HL = 3'd4;

  localparam int MIN_DEADTIME = 1;

  function automatic logic is_dead(state_t s);
    return (s == STATE_DEAD_LH) || (s == STATE_DEAD_HL);
  endfunction

endpackage

// File: rtl/deadtime_timer.sv
// Dead-time interval timer: latches a clamped length on load, counts up,
// and raises a registered expired pulse in the last cycle of the interval.
module deadtime_timer
  import deadtime_pkg::*;
#(
  parameter int bitwidth = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load,
  input  logic                clear,
  input  logic [bitwidth-1:0] value,
  output logic                expired
);

  localparam logic [bitwidth-1:0] ONE     = bitwidth'(1);
  localparam logic [bitwidth-1:0] MIN_VAL = bitwidth'(MIN_DEADTIME);

  logic [bitwidth-1:0] count;
  logic [bitwidth-1:0] limit_m1;
  logic [bitwidth-1:0] clamped;

  assign clamped = (value == '0) ? MIN_VAL : value;

  // expired mirrors (count == limit_m1) one register stage early, so the
  // FSM leaves the dead state after exactly max(value,1) cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count    <= '0;
      limit_m1 <= '0;
      expired  <= 1'b0;
    end else if (clear) begin
      count    <= '0;
      limit_m1 <= '0;
      expired  <= 1'b0;
    end else if (load) begin
      count    <= '0;
      limit_m1 <= clamped - ONE;
      expired  <= (clamped == ONE);
    end else begin
      expired <= 1'b0;
      if (count != limit_m1) begin
        count   <= count + ONE;
        expired <= ((count + ONE) == limit_m1);
      end
    end
  end

endmodule

// File: rtl/deadtime_generator.sv
// Complementary half-bridge gate drive with programmable dead time,
// interlock and latched fault shutdown. Outputs decode the state register.
module deadtime_generator
  import deadtime_pkg::*;
#(
  parameter int bitwidth = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                gate_signal,
  input  logic [bitwidth-1:0] deadtime_rising,
  input  logic [bitwidth-1:0] deadtime_falling,
  input  logic                fault,
  input  logic                fault_clear,
  output logic                high_side,
  output logic                low_side,
  output logic                deadtime_active,
  output logic                fault_latched
);

  state_t              state, next_state;
  logic                timer_load, timer_clear, timer_expired;
  logic [bitwidth-1:0] timer_value;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= STATE_OFF;
    else       state <= next_state;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)            fault_latched <= 1'b0;
    else if (fault)       fault_latched <= 1'b1;
    else if (fault_clear) fault_latched <= 1'b0;
  end

  // The registered fault flag gates the OFF exit, which yields the single
  // OFF cycle after a clear.
  always_comb begin
    next_state = state;
    if (fault || !enable) begin
      next_state = STATE_OFF;
    end else begin
      case (state)
        STATE_OFF:
          if (!fault_latched) next_state = gate_signal ? STATE_DEAD_LH : STATE_LOW_ON;
        STATE_LOW_ON:
          if (gate_signal) next_state = STATE_DEAD_LH;
        STATE_DEAD_LH:
          if (!gate_signal)       next_state = STATE_LOW_ON;
          else if (timer_expired) next_state = STATE_HIGH_ON;
        STATE_HIGH_ON:
          if (!gate_signal) next_state = STATE_DEAD_HL;
        STATE_DEAD_HL:
          if (gate_signal)        next_state = STATE_HIGH_ON;
          else if (timer_expired) next_state = STATE_LOW_ON;
        default:
          next_state = STATE_OFF;
      endcase
    end
  end

  always_comb begin
    timer_load  = is_dead(next_state) && (next_state != state);
    timer_clear = !is_dead(next_state);
    timer_value = (next_state == STATE_DEAD_LH) ? deadtime_rising : deadtime_falling;
  end

  always_comb begin
    high_side       = (state == STATE_HIGH_ON);
    low_side        = (state == STATE_LOW_ON);
    deadtime_active = is_dead(state);
  end

  deadtime_timer #(.bitwidth(bitwidth)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (timer_load),
    .clear   (timer_clear),
    .value   (timer_value),
    .expired (timer_expired)
  );

endmodule
